muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on posedge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset (clears all state on negedge, independent of clk).
REQ-003 SHALL have port: start  input  1  request; sampled on posedge while idle.
REQ-004 SHALL have port: op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL have port: rs_data  input  32  operand A / dividend, taken from register-file ReadData1.
REQ-006 SHALL have port: rt_data  input  32  operand B / divisor, taken from register-file ReadData2.
REQ-007 SHALL have port: busy  output  1  operation in progress.
REQ-008 SHALL have port: done  output  1  one-cycle result-valid pulse.
REQ-009 SHALL have port: hi  output  32  MUL: product[63:32]; DIV: remainder.
REQ-010 SHALL have port: lo  output  32  MUL: product[31:0]; DIV: quotient.
REQ-011 SHALL have port: div_by_zero  output  1  last DIV/DIVU had rt_data == 0; held until next accepted start.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, FIX: IDLE->CALC on start; CALC->FIX after 32 iterations; FIX->IDLE unconditionally.
REQ-013 SHALL accept start only in IDLE, at edge N: latch op, operand magnitudes (signed ops) or raw values (unsigned ops), result signs; clear iteration counter.
REQ-014 SHALL ignore start while busy=1; no queuing.
REQ-015 SHALL perform one iteration per edge N+1..N+32: shift-add for multiply, restoring shift-subtract for divide.
REQ-016 SHALL write hi/lo, with sign correction, at edge N+33; done=1 exactly from edge N+33 to edge N+34.
REQ-017 SHALL drive busy=1 from edge N to edge N+33; busy and done never both 1.
REQ-018 SHALL have fixed latency of 33 cycles for every op, including divide-by-zero.
REQ-019 SHALL, for MULT, negate the 64-bit product when operand signs differ.
REQ-020 SHALL, for DIV, truncate quotient toward zero; remainder takes dividend's sign.
REQ-021 SHALL, for DIV 0x80000000 / 0xFFFFFFFF, produce lo=0x80000000, hi=0.
REQ-022 SHALL, on divisor 0, produce hi=rs_data as sampled at start, lo=0xFFFFFFFF, div_by_zero=1.
REQ-023 SHALL hold hi/lo stable between done pulses; operand input changes after edge N SHALL NOT affect the result.

Reset
REQ-024 SHALL, on reset low, immediately force state=IDLE, busy=0, done=0, hi=0, lo=0, div_by_zero=0, counter=0.
REQ-025 SHALL, on reset asserted mid-CALC/FIX, abort the operation with no done pulse; the first start after reset release SHALL run normally.

Structure
REQ-026 SHALL place op encodings, FSM state encodings and ITER_COUNT=32 in a shared package used by the decode stage.
REQ-027 SHALL be a single module with no sub-modules; the 64-bit shift datapath is shared between multiply and divide.

Verification
REQ-028 SHALL cover MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done exactly 33 cycles after start edge.
REQ-029 SHALL cover MULT 0xFFFFFFFD (-3) x 0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-030 SHALL cover DIV 0xFFFFFFF9 (-7) / 0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; and DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-031 SHALL cover DIVU 0x00000064 / 0 -> hi=0x00000064, lo=0xFFFFFFFF, div_by_zero=1; next MULTU clears div_by_zero at its start edge.
REQ-032 SHALL cover start re-pulsed with new operands at cycle 5 of CALC -> ignored; original result delivered; busy never drops early.
REQ-033 SHALL cover reset asserted at iteration 10 -> busy=0, done=0, hi=lo=0 immediately; no done pulse; subsequent MULTU 6 x 7 -> lo=0x2A, hi=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: opcodes, FSM states
// and the iteration count used by the decode and control logic.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10
    } state_e;

    localparam int unsigned ITER_COUNT = 32;
    localparam int          CNT_W      = $clog2(ITER_COUNT);

    // Magnitude of a 32-bit operand; unsigned ops pass the raw value through.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply / 32/32 divide with a fixed 33-cycle latency.
// One 64-bit shift register and one 34-bit adder serve both operations.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_by_zero
);

    state_e             r_state;
    state_e             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [63:0]        r_acc;
    logic [31:0]        r_opb;
    logic               r_is_div;
    logic               r_neg_lo;
    logic               r_neg_hi;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic               r_done;
    logic               r_dbz;

    logic               w_signed;
    logic               w_accept;
    logic               w_last;
    logic [33:0]        w_lhs;
    logic [33:0]        w_rhs;
    logic [33:0]        w_sum;
    logic [63:0]        w_acc_next;
    logic [63:0]        w_prod;
    logic [31:0]        w_quot;
    logic [31:0]        w_rem;

    assign w_signed = ~op[0];
    assign w_accept = (r_state == S_IDLE) && start;
    assign w_last   = (r_cnt == CNT_W'(ITER_COUNT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_CALC;
            S_CALC:  if (w_last) w_state_next = S_FIX;
            S_FIX:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Multiply adds the multiplicand into the upper half and shifts right;
    // divide trial-subtracts the divisor from the left-shifted remainder.
    always_comb begin
        if (r_is_div) begin
            w_lhs = {1'b0, r_acc[63:31]};
            w_rhs = ~{2'b00, r_opb} + 34'd1;
        end else begin
            w_lhs = {2'b00, r_acc[63:32]};
            w_rhs = r_acc[0] ? {2'b00, r_opb} : 34'd0;
        end
        w_sum = w_lhs + w_rhs;
        if (!r_is_div)
            w_acc_next = {w_sum[32:0], r_acc[31:1]};
        else if (!w_sum[33])
            w_acc_next = {w_sum[31:0], r_acc[30:0], 1'b1};
        else
            w_acc_next = {r_acc[62:0], 1'b0};
    end

    assign w_prod = r_neg_lo ? (64'd0 - r_acc) : r_acc;
    assign w_quot = r_neg_lo ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
    assign w_rem  = r_neg_hi ? (32'd0 - r_acc[63:32]) : r_acc[63:32];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_is_div <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_acc    <= {32'd0, mag32(rs_data, w_signed)};
                r_opb    <= mag32(rt_data, w_signed);
                r_is_div <= op[1];
                r_neg_lo <= w_signed & (rs_data[31] ^ rt_data[31]);
                r_neg_hi <= w_signed & op[1] & rs_data[31];
                r_dbz    <= op[1] && (rt_data == 32'd0);
                r_cnt    <= '0;
            end else if (r_state == S_CALC) begin
                r_acc <= w_acc_next;
                r_cnt <= r_cnt + 1'b1;
            end else if (r_state == S_FIX) begin
                r_done <= 1'b1;
                if (!r_is_div) begin
                    r_hi <= w_prod[63:32];
                    r_lo <= w_prod[31:0];
                end else begin
                    // A zero divisor leaves the dividend as remainder, which the
                    // sign fix restores to the raw rs_data value.
                    r_hi <= w_rem;
                    r_lo <= r_dbz ? 32'hFFFF_FFFF : w_quot;
                end
            end
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus randomized
// operations compared against a plain-arithmetic reference model.
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_unit dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: 64-bit integer arithmetic (SV division truncates toward zero).
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el, output logic edbz);
        longint      sa;
        longint      sb;
        longint      p;
        logic [63:0] up;
        edbz = 1'b0;
        eh   = '0;
        el   = '0;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        case (o)
            2'd0: begin p = sa * sb; eh = p[63:32]; el = p[31:0]; end
            2'd1: begin up = {32'd0, a} * {32'd0, b}; eh = up[63:32]; el = up[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    eh = a; el = 32'hFFFF_FFFF; edbz = 1'b1;
                end else if (o == 2'd2) begin
                    p = sa / sb; el = p[31:0];
                    p = sa % sb; eh = p[31:0];
                end else begin
                    el = a / b; eh = a % b;
                end
            end
        endcase
    endfunction

    // Issues one operation and observes it; operands are scrambled right after
    // the start edge, and an optional extra start is pulsed mid-calculation.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit repulse,
                          output logic [31:0] rh, output logic [31:0] rl, output logic rdbz,
                          output logic dbz_at_start, output int lat,
                          output bit busy_ok, output bit done_one);
        rh = '0; rl = '0; rdbz = 1'b0; lat = -1; busy_ok = 1'b1;
        @(negedge clk);
        op = o; rs_data = a; rt_data = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        rs_data = $urandom; rt_data = $urandom; op = 2'($urandom_range(0, 3));
        dbz_at_start = div_by_zero;
        if (!busy || done) busy_ok = 1'b0;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(posedge clk); #1;
            if (repulse && k == 4) begin
                start = 1'b1; op = 2'd1; rs_data = 32'h1234_5678; rt_data = 32'h0000_0003;
            end
            if (repulse && k == 5) start = 1'b0;
            if (done) begin
                lat = k; rh = hi; rl = lo; rdbz = div_by_zero;
                if (busy) busy_ok = 1'b0;
            end else if (!busy) begin
                busy_ok = 1'b0;
            end
        end
        @(posedge clk); #1;
        done_one = !done && !busy;
        $display("txn op=%0d a=%h b=%h hi=%h lo=%h dbz=%0b lat=%0d", o, a, b, rh, rl, rdbz, lat);
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; op = 2'd0; rs_data = '0; rt_data = '0;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h expected 0", hi); end
        n_checks++; if (lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h expected 0", lo); end
        n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
        reset = 1'b1;
    endtask

    task automatic test_multu_max();
        logic [31:0] rh, rl; logic rd, ds; int lat; bit bok, d1;
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, rh, rl, rd, ds, lat, bok, d1);
        n_checks++; if (rh !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_max_hi: got %h expected fffffffe", rh); end
        n_checks++; if (rl !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_max_lo: got %h expected 00000001", rl); end
        n_checks++; if (lat != 33) begin n_fail++; $display("FAIL multu_max_latency: got %0d expected 33", lat); end
        n_checks++; if (!bok) begin n_fail++; $display("FAIL multu_max_busy: got 0 expected 1"); end
        n_checks++; if (!d1) begin n_fail++; $display("FAIL multu_max_done_pulse: got 0 expected 1"); end
    endtask

    task automatic test_mult_signed();
        logic [31:0] rh, rl; logic rd, ds; int lat; bit bok, d1;
        run_op(2'd0, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0, rh, rl, rd, ds, lat, bok, d1);
        n_checks++; if (rh !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_neg_hi: got %h expected ffffffff", rh); end
        n_checks++; if (rl !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mult_neg_lo: got %h expected ffffffeb", rl); end
    endtask

    task automatic test_div_signed();
        logic [31:0] rh, rl; logic rd, ds; int lat; bit bok, d1;
        run_op(2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, rh, rl, rd, ds, lat, bok, d1);
        n_checks++; if (rl !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_neg_lo: got %h expected fffffffd", rl); end
        n_checks++; if (rh !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_neg_hi: got %h expected ffffffff", rh); end
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, rh, rl, rd, ds, lat, bok, d1);
        n_checks++; if (rl !== 32'h8000_0000) begin n_fail++; $display("FAIL div_ovf_lo: got %h expected 80000000", rl); end
        n_checks++; if (rh !== 32'h0000_0000) begin n_fail++; $display("FAIL div_ovf_hi: got %h expected 00000000", rh); end
        n_checks++; if (lat != 33) begin n_fail++; $display("FAIL div_ovf_latency: got %0d expected 33", lat); end
    endtask

    task automatic test_div_by_zero();
        logic [31:0] rh, rl; logic rd, ds; int lat; bit bok, d1;
        run_op(2'd3, 32'h0000_0064, 32'h0000_0000, 1'b0, rh, rl, rd, ds, lat, bok, d1);
        n_checks++; if (rh !== 32'h0000_0064) begin n_fail++; $display("FAIL dbz_hi: got %h expected 00000064", rh); end
        n_checks++; if (rl !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL dbz_lo: got %h expected ffffffff", rl); end
        n_checks++; if (rd !== 1'b1) begin n_fail++; $display("FAIL dbz_flag: got %b expected 1", rd); end
        n_checks++; if (lat != 33) begin n_fail++; $display("FAIL dbz_latency: got %0d expected 33", lat); end
        n_checks++; if (div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dbz_held: got %b expected 1", div_by_zero); end
        run_op(2'd1, 32'h0000_0005, 32'h0000_0009, 1'b0, rh, rl, rd, ds, lat, bok, d1);
        n_checks++; if (ds !== 1'b0) begin n_fail++; $display("FAIL dbz_clear_at_start: got %b expected 0", ds); end
        n_checks++; if (rl !== 32'd45) begin n_fail++; $display("FAIL dbz_next_lo: got %h expected 0000002d", rl); end
    endtask

    task automatic test_ignore_start();
        logic [31:0] rh, rl; logic rd, ds; int lat; bit bok, d1;
        run_op(2'd0, 32'h0001_0003, 32'hFFFF_FF00, 1'b1, rh, rl, rd, ds, lat, bok, d1);
        n_checks++; if (rh !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL ignore_hi: got %h expected ffffffff", rh); end
        n_checks++; if (rl !== 32'hFEFF_FD00) begin n_fail++; $display("FAIL ignore_lo: got %h expected fefffd00", rl); end
        n_checks++; if (lat != 33) begin n_fail++; $display("FAIL ignore_latency: got %0d expected 33", lat); end
        n_checks++; if (!bok) begin n_fail++; $display("FAIL ignore_busy: got 0 expected 1"); end
        n_checks++; if (!d1) begin n_fail++; $display("FAIL ignore_no_second_op: got 0 expected 1"); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rh, rl; logic rd, ds; int lat; bit bok, d1;
        bit saw_done;
        @(negedge clk);
        op = 2'd1; rs_data = 32'hFFFF_0000; rt_data = 32'h0001_2345; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL midreset_done: got %b expected 0", done); end
        n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL midreset_hi: got %h expected 0", hi); end
        n_checks++; if (lo !== 32'd0) begin n_fail++; $display("FAIL midreset_lo: got %h expected 0", lo); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        saw_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        n_checks++; if (saw_done) begin n_fail++; $display("FAIL midreset_no_done: got 1 expected 0"); end
        run_op(2'd1, 32'd6, 32'd7, 1'b0, rh, rl, rd, ds, lat, bok, d1);
        n_checks++; if (rl !== 32'h0000_002A) begin n_fail++; $display("FAIL after_reset_lo: got %h expected 0000002a", rl); end
        n_checks++; if (rh !== 32'h0000_0000) begin n_fail++; $display("FAIL after_reset_hi: got %h expected 00000000", rh); end
        n_checks++; if (lat != 33) begin n_fail++; $display("FAIL after_reset_latency: got %0d expected 33", lat); end
    endtask

    task automatic test_random();
        logic [31:0] rh, rl, eh, el, a, b; logic rd, ds, ed; int lat; bit bok, d1;
        logic [1:0] o;
        for (int t = 0; t < 30; t++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'($urandom_range(1, 15));
                3: a = 32'h8000_0000;
                default: ;
            endcase
            model(o, a, b, eh, el, ed);
            run_op(o, a, b, 1'b0, rh, rl, rd, ds, lat, bok, d1);
            n_checks++; if (rh !== eh) begin n_fail++; $display("FAIL rand_hi[%0d]: got %h expected %h", t, rh, eh); end
            n_checks++; if (rl !== el) begin n_fail++; $display("FAIL rand_lo[%0d]: got %h expected %h", t, rl, el); end
            n_checks++; if (rd !== ed) begin n_fail++; $display("FAIL rand_dbz[%0d]: got %b expected %b", t, rd, ed); end
            n_checks++; if (lat != 33 || !bok) begin n_fail++; $display("FAIL rand_timing[%0d]: got lat %0d busy_ok %0b expected 33 1", t, lat, bok); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_multu_max();
        test_mult_signed();
        test_div_signed();
        test_div_by_zero();
        test_ignore_start();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
